// File: rtl/cpu_pkg.sv
// Shared CPU definitions: command codes consumed by the control FSM and
// the opcode/funct encodings the instruction decoder recognises.
package cpu_pkg;

    localparam int unsigned CMD_W = 4;
    localparam int unsigned OP_W  = 6;

    typedef enum logic [CMD_W-1:0] {
        CMD_LW      = 4'd0,
        CMD_SW      = 4'd1,
        CMD_J       = 4'd2,
        CMD_JR      = 4'd3,
        CMD_JAL     = 4'd4,
        CMD_BEQ     = 4'd5,
        CMD_BNE     = 4'd6,
        CMD_XORI    = 4'd7,
        CMD_ADDI    = 4'd8,
        CMD_ADD     = 4'd9,
        CMD_SUB     = 4'd10,
        CMD_SLT     = 4'd11,
        CMD_ILLEGAL = 4'd15
    } cmd_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_ADD   = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB   = 6'h22;
    localparam logic [OP_W-1:0] FN_SLT   = 6'h2A;

    // Memory-access commands
    function automatic logic is_mem_cmd(input cmd_e c);
        return (c == CMD_LW) || (c == CMD_SW);
    endfunction

    // Control-transfer commands
    function automatic logic is_ctrl_cmd(input cmd_e c);
        return (c == CMD_J) || (c == CMD_JAL) || (c == CMD_JR) ||
               (c == CMD_BEQ) || (c == CMD_BNE);
    endfunction

endpackage

// File: rtl/instr_decoder_if.sv
// Decoder bus: load strobe/word from the control side, registered decode
// results back. Counter signals exist only when DECODER_PERF_EN is defined.
interface instr_decoder_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 32
);
    logic              irWe;
    logic [WORD_W-1:0] memData;
    logic [3:0]        cmd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [WORD_W-1:0] immSx;
    logic [25:0]       target;
    logic              cmdValid;
    logic              illegal;
`ifdef DECODER_PERF_EN
    logic              cntClr;
    logic [CNT_W-1:0]  instrCnt;
    logic [CNT_W-1:0]  memCnt;
    logic [CNT_W-1:0]  ctrlCnt;

    modport master (output irWe, memData, cntClr,
                    input  cmd, rs, rt, rd, imm, immSx, target, cmdValid, illegal,
                           instrCnt, memCnt, ctrlCnt);
    modport slave  (input  irWe, memData, cntClr,
                    output cmd, rs, rt, rd, imm, immSx, target, cmdValid, illegal,
                           instrCnt, memCnt, ctrlCnt);
`else
    modport master (output irWe, memData,
                    input  cmd, rs, rt, rd, imm, immSx, target, cmdValid, illegal);
    modport slave  (input  irWe, memData,
                    output cmd, rs, rt, rd, imm, immSx, target, cmdValid, illegal);
`endif
endinterface

// File: rtl/instr_field_decode.sv
// Combinational opcode/funct decode of one 32-bit instruction word.
module instr_field_decode
    import cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output cmd_e        cmd_o,
    output logic        legal_o
);

    logic [OP_W-1:0] opcode_c;
    logic [OP_W-1:0] funct_c;
    logic            unused_c;

    assign opcode_c = instr_i[31:26];
    assign funct_c  = instr_i[5:0];
    assign unused_c = ^instr_i[25:6];

    // Map opcode (or funct for R-type) to a command; unknown encodings are illegal
    always_comb begin
        cmd_o = CMD_ILLEGAL;
        case (opcode_c)
            OP_LW:   cmd_o = CMD_LW;
            OP_SW:   cmd_o = CMD_SW;
            OP_J:    cmd_o = CMD_J;
            OP_JAL:  cmd_o = CMD_JAL;
            OP_BEQ:  cmd_o = CMD_BEQ;
            OP_BNE:  cmd_o = CMD_BNE;
            OP_XORI: cmd_o = CMD_XORI;
            OP_ADDI: cmd_o = CMD_ADDI;
            OP_RTYPE: begin
                case (funct_c)
                    FN_JR:   cmd_o = CMD_JR;
                    FN_ADD:  cmd_o = CMD_ADD;
                    FN_SUB:  cmd_o = CMD_SUB;
                    FN_SLT:  cmd_o = CMD_SLT;
                    default: cmd_o = CMD_ILLEGAL;
                endcase
            end
            default: cmd_o = CMD_ILLEGAL;
        endcase
    end

    assign legal_o = (cmd_o != CMD_ILLEGAL);

endmodule

// File: rtl/instr_decoder.sv
// Instruction register + registered decode with sticky illegal-instruction halt.
// Optional performance counters are built when DECODER_PERF_EN is defined.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    instr_decoder_if.slave bus
);

    logic [WORD_W-1:0] ir_q;
    cmd_e              cmd_q;
    logic              valid_q;
    logic              illegal_q;
    cmd_e              dec_cmd;
    logic              dec_legal;
    logic              load_c;
    logic              unused_c;

    // Once halted, further load strobes are ignored
    assign load_c = bus.irWe & ~illegal_q;

    instr_field_decode u_decode (
        .instr_i (bus.memData[31:0]),
        .cmd_o   (dec_cmd),
        .legal_o (dec_legal)
    );

    // IR, command, valid pulse and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q      <= '0;
            cmd_q     <= CMD_ILLEGAL;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= load_c;
            if (load_c) begin
                ir_q  <= bus.memData;
                cmd_q <= dec_cmd;
                if (!dec_legal) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    assign bus.cmd      = cmd_q;
    assign bus.rs       = ir_q[25:21];
    assign bus.rt       = ir_q[20:16];
    assign bus.rd       = ir_q[15:11];
    assign bus.imm      = ir_q[15:0];
    assign bus.immSx    = {{(WORD_W-16){ir_q[15]}}, ir_q[15:0]};
    assign bus.target   = ir_q[25:0];
    assign bus.cmdValid = valid_q;
    assign bus.illegal  = illegal_q;

`ifdef DECODER_PERF_EN
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] mem_cnt_q,   mem_cnt_d;
    logic [CNT_W-1:0] ctrl_cnt_q,  ctrl_cnt_d;
    logic             count_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + CNT_W'(1);
    endfunction

    assign count_c  = load_c & dec_legal;
    assign unused_c = ^ir_q[WORD_W-1:26];

    // Counter next-state: clear first, then count the accepted legal load
    always_comb begin
        instr_cnt_d = instr_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        ctrl_cnt_d  = ctrl_cnt_q;
        if (!illegal_q) begin
            if (bus.cntClr) begin
                instr_cnt_d = '0;
                mem_cnt_d   = '0;
                ctrl_cnt_d  = '0;
            end
            if (count_c) begin
                instr_cnt_d = sat_inc(instr_cnt_d);
                if (is_mem_cmd(dec_cmd)) begin
                    mem_cnt_d = sat_inc(mem_cnt_d);
                end
                if (is_ctrl_cmd(dec_cmd)) begin
                    ctrl_cnt_d = sat_inc(ctrl_cnt_d);
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= '0;
            mem_cnt_q   <= '0;
            ctrl_cnt_q  <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            ctrl_cnt_q  <= ctrl_cnt_d;
        end
    end

    assign bus.instrCnt = instr_cnt_q;
    assign bus.memCnt   = mem_cnt_q;
    assign bus.ctrlCnt  = ctrl_cnt_q;
`else
    assign unused_c = ^{ir_q[WORD_W-1:26], CNT_W};
`endif

endmodule
